// File: rtl/alu_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq_if
// Brief    : Start/ready/valid handshake bundle between the control unit
//            (master) and the sequential ALU (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface alu_seq_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             c_in;
    logic             ready;
    logic             valid;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic [3:0]       nzvc;
    logic             illegal;

    modport master (
        output start, op, A, B, c_in,
        input  ready, valid, result, result_hi, nzvc, illegal
    );

    modport slave (
        input  start, op, A, B, c_in,
        output ready, valid, result, result_hi, nzvc, illegal
    );
endinterface
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq
// Brief    : Registered WIDTH-bit ALU with start/ready/valid handshake.
//            Single-cycle arithmetic/logic/shift ops; optional multi-cycle
//            unsigned shift-add multiply built when ALU_MUL_EN is defined.
//            Without ALU_MUL_EN, op 12 is treated as illegal.
// Revision : 1.0 - initial release
// ============================================================================
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic     clock,
    input  logic     reset,
    alu_seq_if.slave bus
);

    localparam logic [3:0] c_OP_ADD = 4'd0;
    localparam logic [3:0] c_OP_SUB = 4'd1;
    localparam logic [3:0] c_OP_AND = 4'd2;
    localparam logic [3:0] c_OP_OR  = 4'd3;
    localparam logic [3:0] c_OP_INC = 4'd4;
    localparam logic [3:0] c_OP_DEC = 4'd5;
    localparam logic [3:0] c_OP_ADC = 4'd6;
    localparam logic [3:0] c_OP_SBC = 4'd7;
    localparam logic [3:0] c_OP_XOR = 4'd8;
    localparam logic [3:0] c_OP_SHL = 4'd9;
    localparam logic [3:0] c_OP_SHR = 4'd10;
    localparam logic [3:0] c_OP_ASR = 4'd11;

    localparam logic [WIDTH-1:0] c_MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] c_MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic             ready;
    logic             accept;

    // single-cycle datapath results
    logic [WIDTH:0]   sc_tmp;
    logic [WIDTH-1:0] sc_res;
    logic             sc_arith;
    logic             sc_n;
    logic             sc_z;
    logic             sc_v;
    logic             sc_c;
    logic             sc_illegal;
    logic             sc_is_mul;

    // registered outputs
    logic             valid_q,   valid_d;
    logic [WIDTH-1:0] result_q,  result_d;
    logic [3:0]       nzvc_q,    nzvc_d;
    logic             illegal_q, illegal_d;

    assign accept = bus.start & ready;

`ifdef ALU_MUL_EN
    localparam logic [3:0] c_OP_MUL  = 4'd12;
    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_MUL  = 1'b1;
    localparam int         CNT_W     = $clog2(WIDTH);

    logic [0:0]         state_q,     state_d;
    logic [WIDTH-1:0]   result_hi_q, result_hi_d;
    logic [2*WIDTH-1:0] mcand_q,     mcand_d;
    logic [WIDTH-1:0]   mplier_q,    mplier_d;
    logic [2*WIDTH-1:0] acc_q,       acc_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic [2*WIDTH-1:0] mul_sum;
    logic               mul_last;
    logic               mul_hi_nz;

    // FSM state register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= c_ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: a MUL accept parks us in MUL until the last iteration
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_ST_IDLE: if (accept && sc_is_mul) state_d = c_ST_MUL;
            c_ST_MUL:  if (mul_last)            state_d = c_ST_IDLE;
        endcase
    end

    // FSM outputs: only IDLE may accept a new request
    always_comb begin
        ready = (state_q == c_ST_IDLE);
    end

    // one shift-add step; the sum on the last step is the full product
    always_comb begin
        mul_sum   = acc_q + (mplier_q[0] ? mcand_q : '0);
        mul_last  = (cnt_q == CNT_W'(WIDTH - 1));
        mul_hi_nz = |mul_sum[2*WIDTH-1:WIDTH];
    end

    assign bus.result_hi = result_hi_q;
`else
    // no multi-cycle op exists, so the block is always ready
    always_comb begin
        ready = 1'b1;
    end

    assign bus.result_hi = '0;
`endif

    // single-cycle ALU: result and flags from the current operands
    always_comb begin
        sc_tmp     = '0;
        sc_res     = '0;
        sc_arith   = 1'b0;
        sc_v       = 1'b0;
        sc_c       = 1'b0;
        sc_illegal = 1'b0;
        sc_is_mul  = 1'b0;
        case (bus.op)
            c_OP_ADD: begin
                sc_arith = 1'b1;
                sc_tmp   = {1'b0, bus.A} + {1'b0, bus.B};
                sc_v     = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (sc_tmp[WIDTH-1] != bus.A[WIDTH-1]);
            end
            c_OP_ADC: begin
                sc_arith = 1'b1;
                sc_tmp   = {1'b0, bus.A} + {1'b0, bus.B} + {{WIDTH{1'b0}}, bus.c_in};
                sc_v     = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (sc_tmp[WIDTH-1] != bus.A[WIDTH-1]);
            end
            c_OP_SUB: begin
                sc_arith = 1'b1;
                sc_tmp   = {1'b0, bus.A} - {1'b0, bus.B};
                sc_v     = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (sc_tmp[WIDTH-1] != bus.A[WIDTH-1]);
            end
            c_OP_SBC: begin
                sc_arith = 1'b1;
                sc_tmp   = {1'b0, bus.A} - {1'b0, bus.B} - {{WIDTH{1'b0}}, bus.c_in};
                sc_v     = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (sc_tmp[WIDTH-1] != bus.A[WIDTH-1]);
            end
            c_OP_INC: begin
                sc_arith = 1'b1;
                sc_tmp   = {1'b0, bus.A} + (WIDTH+1)'(1);
                sc_v     = (bus.A == c_MAX_POS);
            end
            c_OP_DEC: begin
                sc_arith = 1'b1;
                sc_tmp   = {1'b0, bus.A} - (WIDTH+1)'(1);
                sc_v     = (bus.A == c_MIN_NEG);
            end
            c_OP_AND: sc_res = bus.A & bus.B;
            c_OP_OR:  sc_res = bus.A | bus.B;
            c_OP_XOR: sc_res = bus.A ^ bus.B;
            c_OP_SHL: begin
                sc_res = {bus.A[WIDTH-2:0], 1'b0};
                sc_c   = bus.A[WIDTH-1];
                sc_v   = bus.A[WIDTH-1] ^ bus.A[WIDTH-2];
            end
            c_OP_SHR: begin
                sc_res = {1'b0, bus.A[WIDTH-1:1]};
                sc_c   = bus.A[0];
            end
            c_OP_ASR: begin
                sc_res = {bus.A[WIDTH-1], bus.A[WIDTH-1:1]};
                sc_c   = bus.A[0];
            end
`ifdef ALU_MUL_EN
            c_OP_MUL: sc_is_mul = 1'b1;
`endif
            default:  sc_illegal = 1'b1;
        endcase
        // carry/borrow is the extra top bit of the widened temporary
        if (sc_arith) begin
            sc_res = sc_tmp[WIDTH-1:0];
            sc_c   = sc_tmp[WIDTH];
        end
        sc_n = sc_res[WIDTH-1];
        sc_z = (sc_res == '0);
    end

    // next values of the result registers and multiplier working state
    always_comb begin
        valid_d     = 1'b0;
        result_d    = result_q;
        nzvc_d      = nzvc_q;
        illegal_d   = illegal_q;
`ifdef ALU_MUL_EN
        result_hi_d = result_hi_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
`endif
        if (accept && !sc_is_mul) begin
            valid_d     = 1'b1;
            result_d    = sc_illegal ? '0 : sc_res;
            nzvc_d      = sc_illegal ? 4'b0000 : {sc_n, sc_z, sc_v, sc_c};
            illegal_d   = sc_illegal;
`ifdef ALU_MUL_EN
            result_hi_d = '0;
`endif
        end
`ifdef ALU_MUL_EN
        else if (accept) begin
            // latch operands so A/B may change while the multiply runs
            mcand_d  = {{WIDTH{1'b0}}, bus.A};
            mplier_d = bus.B;
            acc_d    = '0;
            cnt_d    = '0;
        end else if (state_q == c_ST_MUL) begin
            acc_d    = mul_sum;
            mcand_d  = {mcand_q[2*WIDTH-2:0], 1'b0};
            mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
            cnt_d    = cnt_q + 1'b1;
            if (mul_last) begin
                valid_d     = 1'b1;
                result_d    = mul_sum[WIDTH-1:0];
                result_hi_d = mul_sum[2*WIDTH-1:WIDTH];
                nzvc_d      = {mul_sum[2*WIDTH-1], (mul_sum == '0), mul_hi_nz, mul_hi_nz};
                illegal_d   = 1'b0;
            end
        end
`endif
    end

    // result and working registers; reset clears everything and aborts a MUL
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q     <= 1'b0;
            result_q    <= '0;
            nzvc_q      <= 4'b0000;
            illegal_q   <= 1'b0;
`ifdef ALU_MUL_EN
            result_hi_q <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
`endif
        end else begin
            valid_q     <= valid_d;
            result_q    <= result_d;
            nzvc_q      <= nzvc_d;
            illegal_q   <= illegal_d;
`ifdef ALU_MUL_EN
            result_hi_q <= result_hi_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign bus.ready   = ready;
    assign bus.valid   = valid_q;
    assign bus.result  = result_q;
    assign bus.nzvc    = nzvc_q;
    assign bus.illegal = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_seq
// Brief    : Self-checking bench for alu_seq (WIDTH=8) with an arithmetic
//            reference model; multiply scenarios build only with ALU_MUL_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_seq;
    localparam int     WIDTH = 8;
    localparam longint M     = 64'd1 << WIDTH;
    localparam int     MAXV  = (1 << WIDTH) - 1;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;

    alu_seq_if #(.WIDTH(WIDTH)) bus ();
    alu_seq #(.WIDTH(WIDTH)) dut (.clock(clock), .reset(reset), .bus(bus));

    always #5 clock = ~clock;

    // expected outputs produced by ref_model
    longint     e_res;
    longint     e_hi;
    logic [3:0] e_f;
    logic       e_ill;

    // reference model: integer arithmetic on unsigned/signed interpretations
    task automatic ref_model(input int op, input longint a, input longint b, input int cin);
        longint sa, sb, u, s, p;
        bit     arith, is_mul;
        sa = (a >= M / 2) ? a - M : a;
        sb = (b >= M / 2) ? b - M : b;
        arith = 0; is_mul = 0; u = 0; s = 0;
        e_res = 0; e_hi = 0; e_f = 4'b0000; e_ill = 1'b0;
        case (op)
            0:  begin u = a + b;       s = sa + sb;       arith = 1; end
            1:  begin u = a - b;       s = sa - sb;       arith = 1; end
            4:  begin u = a + 1;       s = sa + 1;        arith = 1; end
            5:  begin u = a - 1;       s = sa - 1;        arith = 1; end
            6:  begin u = a + b + cin; s = sa + sb + cin; arith = 1; end
            7:  begin u = a - b - cin; s = sa - sb - cin; arith = 1; end
            2:  e_res = a & b;
            3:  e_res = a | b;
            8:  e_res = a ^ b;
            9:  begin
                e_res  = (a * 2) % M;
                e_f[0] = (a >= M / 2);
                e_f[1] = (((a / (M / 2)) % 2) != ((a / (M / 4)) % 2));
            end
            10: begin e_res = a / 2; e_f[0] = (a % 2) == 1; end
            11: begin e_res = a / 2 + ((a >= M / 2) ? M / 2 : 0); e_f[0] = (a % 2) == 1; end
`ifdef ALU_MUL_EN
            12: begin
                is_mul = 1;
                p      = a * b;
                e_res  = p % M;
                e_hi   = p / M;
                e_f    = {p >= (M * M) / 2, p == 0, e_hi != 0, e_hi != 0};
            end
`endif
            default: e_ill = 1'b1;
        endcase
        if (arith) begin
            e_res  = ((u % M) + M) % M;
            e_f[0] = (u < 0) || (u >= M);
            e_f[1] = (s < -(M / 2)) || (s >= M / 2);
        end
        if (!e_ill && !is_mul) begin
            e_f[3] = (e_res >= M / 2);
            e_f[2] = (e_res == 0);
        end
    endtask

    task automatic drive(input int op, input longint a, input longint b, input int cin);
        bus.start = 1'b1;
        bus.op    = 4'(op);
        bus.A     = WIDTH'(a);
        bus.B     = WIDTH'(b);
        bus.c_in  = cin[0];
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        if ({bus.ready, bus.valid, bus.result, bus.result_hi, bus.nzvc, bus.illegal} !== {1'b1, 1'b0, 8'h00, 8'h00, 4'h0, 1'b0}) begin
            bad++;
            $display("FAIL reset_state: got rdy=%b vld=%b res=%h hi=%h nzvc=%b ill=%b want rdy=1 vld=0 res=00 hi=00 nzvc=0000 ill=0",
                     bus.ready, bus.valid, bus.result, bus.result_hi, bus.nzvc, bus.illegal);
        end
        total++;
        reset = 1'b0;
    endtask

    task automatic test_directed();
        int         d_op [5] = '{0, 11, 9, 13, 0};
        logic [7:0] d_a  [5] = '{8'h7F, 8'h81, 8'h40, 8'h55, 8'h02};
        logic [7:0] d_b  [5] = '{8'h01, 8'h00, 8'h00, 8'hAA, 8'h03};
        logic [7:0] d_r  [5] = '{8'h80, 8'hC0, 8'h80, 8'h00, 8'h05};
        logic [3:0] d_f  [5] = '{4'b1010, 4'b1001, 4'b1010, 4'b0000, 4'b0000};
        logic       d_il [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            drive(d_op[i], longint'(d_a[i]), longint'(d_b[i]), 0);
            @(posedge clock); #1;
            if ({bus.ready, bus.valid, bus.illegal, bus.nzvc, bus.result_hi, bus.result} !== {1'b1, 1'b1, d_il[i], d_f[i], 8'h00, d_r[i]}) begin
                bad++;
                $display("FAIL directed[%0d] op=%0d: got rdy=%b vld=%b ill=%b nzvc=%b hi=%h res=%h want rdy=1 vld=1 ill=%b nzvc=%b hi=00 res=%h",
                         i, d_op[i], bus.ready, bus.valid, bus.illegal, bus.nzvc, bus.result_hi, bus.result, d_il[i], d_f[i], d_r[i]);
            end
            total++;
            bus.start = 1'b0;
            @(posedge clock); #1;
        end
    endtask

    task automatic test_back_to_back();
        drive(1, 'h00, 'h01, 0);
        @(posedge clock); #1;
        if ({bus.ready, bus.valid, bus.nzvc, bus.result} !== {1'b1, 1'b1, 4'b1001, 8'hFF}) begin
            bad++;
            $display("FAIL b2b_sub: got rdy=%b vld=%b nzvc=%b res=%h want rdy=1 vld=1 nzvc=1001 res=ff",
                     bus.ready, bus.valid, bus.nzvc, bus.result);
        end
        total++;
        drive(6, 'hFF, 'h00, 1);
        @(posedge clock); #1;
        if ({bus.ready, bus.valid, bus.nzvc, bus.result} !== {1'b1, 1'b1, 4'b0101, 8'h00}) begin
            bad++;
            $display("FAIL b2b_adc: got rdy=%b vld=%b nzvc=%b res=%h want rdy=1 vld=1 nzvc=0101 res=00",
                     bus.ready, bus.valid, bus.nzvc, bus.result);
        end
        total++;
        bus.start = 1'b0;
        @(posedge clock); #1;
        if (bus.valid !== 1'b0) begin
            bad++;
            $display("FAIL b2b_valid_drop: got vld=%b want vld=0", bus.valid);
        end
        total++;
    endtask

    task automatic test_random();
        int     op, cin;
        longint a, b;
        for (int i = 0; i < 300; i++) begin
            op  = int'($urandom_range(0, 15));
`ifdef ALU_MUL_EN
            if (op == 12) op = 0;
`endif
            a   = longint'($urandom_range(0, MAXV));
            b   = longint'($urandom_range(0, MAXV));
            cin = int'($urandom_range(0, 1));
            if (i % 40 == 0) a = (i % 80 == 0) ? longint'(MAXV / 2) : longint'(MAXV / 2 + 1);
            drive(op, a, b, cin);
            @(posedge clock); #1;
            ref_model(op, a, b, cin);
            if ({bus.ready, bus.valid, bus.illegal, bus.nzvc, bus.result_hi, bus.result} !==
                {1'b1, 1'b1, e_ill, e_f, e_hi[WIDTH-1:0], e_res[WIDTH-1:0]}) begin
                bad++;
                $display("FAIL random[%0d] op=%0d a=%h b=%h cin=%0d: got rdy=%b vld=%b ill=%b nzvc=%b hi=%h res=%h want rdy=1 vld=1 ill=%b nzvc=%b hi=%h res=%h",
                         i, op, a[7:0], b[7:0], cin, bus.ready, bus.valid, bus.illegal, bus.nzvc, bus.result_hi, bus.result,
                         e_ill, e_f, e_hi[7:0], e_res[7:0]);
            end
            total++;
        end
        bus.start = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic test_hold();
        drive(0, 'h03, 'h04, 0);
        @(posedge clock); #1;
        bus.start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.A  = WIDTH'($urandom);
            bus.B  = WIDTH'($urandom);
            bus.op = 4'($urandom);
            @(posedge clock); #1;
            if ({bus.valid, bus.illegal, bus.nzvc, bus.result} !== {1'b0, 1'b0, 4'b0000, 8'h07}) begin
                bad++;
                $display("FAIL hold[%0d]: got vld=%b ill=%b nzvc=%b res=%h want vld=0 ill=0 nzvc=0000 res=07",
                         i, bus.valid, bus.illegal, bus.nzvc, bus.result);
            end
            total++;
        end
    endtask

`ifdef ALU_MUL_EN
    task automatic test_mul();
        int     cyc, busy;
        longint a, b;
        drive(12, 'h10, 'h10, 0);
        @(posedge clock); #1;
        drive(0, 'h01, 'h01, 0);   // request while busy: must be dropped
        cyc = 0; busy = 0;
        while (bus.valid !== 1'b1 && cyc < 40) begin
            if (bus.ready === 1'b0) busy++;
            @(posedge clock); #1;
            cyc++;
            if (cyc == 4) bus.start = 1'b0;
        end
        if (cyc !== 8 || busy !== 8) begin
            bad++;
            $display("FAIL mul_latency: got valid_after=%0d busy=%0d want valid_after=8 busy=8", cyc, busy);
        end
        total++;
        if ({bus.ready, bus.illegal, bus.nzvc, bus.result_hi, bus.result} !== {1'b1, 1'b0, 4'b0011, 8'h01, 8'h00}) begin
            bad++;
            $display("FAIL mul_0x10: got rdy=%b ill=%b nzvc=%b hi=%h res=%h want rdy=1 ill=0 nzvc=0011 hi=01 res=00",
                     bus.ready, bus.illegal, bus.nzvc, bus.result_hi, bus.result);
        end
        total++;
        @(posedge clock); #1;
        if ({bus.valid, bus.result_hi, bus.result} !== {1'b0, 8'h01, 8'h00}) begin
            bad++;
            $display("FAIL mul_single_pulse: got vld=%b hi=%h res=%h want vld=0 hi=01 res=00",
                     bus.valid, bus.result_hi, bus.result);
        end
        total++;
        // each new MUL is issued in the valid cycle of the previous one
        for (int i = 0; i < 20; i++) begin
            a = (i == 0) ? longint'(MAXV) : longint'($urandom_range(0, MAXV));
            b = (i == 0) ? longint'(MAXV) : longint'($urandom_range(0, MAXV));
            if (i == 1) b = 0;
            drive(12, a, b, int'($urandom_range(0, 1)));
            @(posedge clock); #1;
            bus.start = 1'b0;
            cyc = 0;
            while (bus.valid !== 1'b1 && cyc < 40) begin
                bus.A  = WIDTH'($urandom);
                bus.B  = WIDTH'($urandom);
                bus.op = 4'($urandom);
                @(posedge clock); #1;
                cyc++;
            end
            ref_model(12, a, b, 0);
            if (cyc !== WIDTH || {bus.ready, bus.illegal, bus.nzvc, bus.result_hi, bus.result} !==
                {1'b1, 1'b0, e_f, e_hi[WIDTH-1:0], e_res[WIDTH-1:0]}) begin
                bad++;
                $display("FAIL mul_random[%0d] a=%h b=%h: got lat=%0d rdy=%b ill=%b nzvc=%b hi=%h res=%h want lat=%0d rdy=1 ill=0 nzvc=%b hi=%h res=%h",
                         i, a[7:0], b[7:0], cyc, bus.ready, bus.illegal, bus.nzvc, bus.result_hi, bus.result,
                         WIDTH, e_f, e_hi[7:0], e_res[7:0]);
            end
            total++;
        end
    endtask

    task automatic test_mul_reset();
        int pulses;
        drive(12, 'hFF, 'hFF, 0);
        @(posedge clock); #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;               // asserted during the 4th busy cycle
        @(posedge clock); #1;
        reset = 1'b0;
        if ({bus.ready, bus.valid, bus.result, bus.result_hi, bus.nzvc, bus.illegal} !== {1'b1, 1'b0, 8'h00, 8'h00, 4'h0, 1'b0}) begin
            bad++;
            $display("FAIL mul_reset_state: got rdy=%b vld=%b res=%h hi=%h nzvc=%b ill=%b want rdy=1 vld=0 res=00 hi=00 nzvc=0000 ill=0",
                     bus.ready, bus.valid, bus.result, bus.result_hi, bus.nzvc, bus.illegal);
        end
        total++;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clock); #1;
            if (bus.valid === 1'b1) pulses++;
        end
        if (pulses !== 0 || bus.result_hi !== 8'h00) begin
            bad++;
            $display("FAIL mul_reset_no_valid: got pulses=%0d hi=%h want pulses=0 hi=00", pulses, bus.result_hi);
        end
        total++;
    endtask
`else
    task automatic test_op12_illegal();
        for (int i = 0; i < 4; i++) begin
            drive(12, longint'($urandom_range(1, MAXV)), longint'($urandom_range(1, MAXV)), 0);
            @(posedge clock); #1;
            if ({bus.ready, bus.valid, bus.illegal, bus.nzvc, bus.result_hi, bus.result} !== {1'b1, 1'b1, 1'b1, 4'b0000, 8'h00, 8'h00}) begin
                bad++;
                $display("FAIL op12_illegal[%0d]: got rdy=%b vld=%b ill=%b nzvc=%b hi=%h res=%h want rdy=1 vld=1 ill=1 nzvc=0000 hi=00 res=00",
                         i, bus.ready, bus.valid, bus.illegal, bus.nzvc, bus.result_hi, bus.result);
            end
            total++;
        end
        drive(3, 'h0F, 'hF0, 0);
        @(posedge clock); #1;
        if ({bus.valid, bus.illegal, bus.nzvc, bus.result} !== {1'b1, 1'b0, 4'b1000, 8'hFF}) begin
            bad++;
            $display("FAIL op12_clear: got vld=%b ill=%b nzvc=%b res=%h want vld=1 ill=0 nzvc=1000 res=ff",
                     bus.valid, bus.illegal, bus.nzvc, bus.result);
        end
        total++;
        bus.start = 1'b0;
        @(posedge clock); #1;
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b0;
        bus.op    = 4'd0;
        bus.A     = '0;
        bus.B     = '0;
        bus.c_in  = 1'b0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_hold();
`ifdef ALU_MUL_EN
        test_mul();
        test_mul_reset();
`else
        test_op12_illegal();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
